// File: rtl/register_file_32x32bit.sv
// 32 x 32-bit register file: one synchronous write port, two registered read ports.
// Reads that hit the address being written in the same cycle return the new data.
module register_file_32x32bit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] In,
    input  logic [ADDR_WIDTH-1:0] address_w,
    input  logic                  enable_w,
    input  logic [ADDR_WIDTH-1:0] address_a,
    input  logic                  enable_a,
    input  logic [ADDR_WIDTH-1:0] address_b,
    input  logic                  enable_b,
    output logic [DATA_WIDTH-1:0] OutA,
    output logic [DATA_WIDTH-1:0] OutB
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_a_data;
    logic [DATA_WIDTH-1:0] rd_b_data;

    // Write-first bypass: a same-cycle write to the read address wins over the array.
    always_comb begin
        rd_a_data = mem[address_a];
        rd_b_data = mem[address_b];
        if (enable_w && (address_w == address_a)) begin
            rd_a_data = In;
        end
        if (enable_w && (address_w == address_b)) begin
            rd_b_data = In;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            OutA <= '0;
            OutB <= '0;
        end else begin
            if (enable_w) begin
                mem[address_w] <= In;
            end
            if (enable_a) begin
                OutA <= rd_a_data;
            end
            if (enable_b) begin
                OutB <= rd_b_data;
            end
        end
    end

endmodule

// File: tb/tb_register_file_32x32bit.sv
// Scoreboard bench for register_file_32x32bit: expected read data is queued when a
// read is issued and compared one edge later when the registered output appears.
module tb_register_file_32x32bit;

    logic        clk;
    logic        rst;
    logic [31:0] In;
    logic [4:0]  address_w;
    logic        enable_w;
    logic [4:0]  address_a;
    logic        enable_a;
    logic [4:0]  address_b;
    logic        enable_b;
    logic [31:0] OutA;
    logic [31:0] OutB;

    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    int vectors = 0;
    int errors  = 0;

    register_file_32x32bit #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .In(In),
        .address_w(address_w), .enable_w(enable_w),
        .address_a(address_a), .enable_a(enable_a),
        .address_b(address_b), .enable_b(enable_b),
        .OutA(OutA), .OutB(OutB)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    // Inputs change on the falling edge only.
    task automatic drive(input logic r, input logic we, input logic [4:0] aw, input logic [31:0] din,
                         input logic ea, input logic [4:0] aa, input logic eb, input logic [4:0] ab);
        @(negedge clk);
        rst = r; enable_w = we; address_w = aw; In = din;
        enable_a = ea; address_a = aa; enable_b = eb; address_b = ab;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] e;
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 1'b1, 5'($urandom_range(31, 0)), $urandom, 1'b1, 5'($urandom_range(31, 0)),
                  1'b1, 5'($urandom_range(31, 0)));
            settle();
        end
        exp_a.push_back(32'h0); exp_b.push_back(32'h0);
        e = exp_a.pop_front(); vectors++;
        if (OutA !== e) begin errors++; $display("FAIL reset_outa got=%h exp=%h", OutA, e); end
        e = exp_b.pop_front(); vectors++;
        if (OutB !== e) begin errors++; $display("FAIL reset_outb got=%h exp=%h", OutB, e); end
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 5'd0, $urandom, 1'b1, 5'(i), 1'b1, 5'(31 - i));
            exp_a.push_back(32'h0); exp_b.push_back(32'h0);
            settle();
            e = exp_a.pop_front(); vectors++;
            if (OutA !== e) begin errors++; $display("FAIL reset_clear_a addr=%0d got=%h exp=%h", i, OutA, e); end
            e = exp_b.pop_front(); vectors++;
            if (OutB !== e) begin errors++; $display("FAIL reset_clear_b addr=%0d got=%h exp=%h", 31 - i, OutB, e); end
        end
    endtask

    task automatic test_fill_readback();
        logic [31:0] e;
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b1, 5'(i), 32'(2 * i), 1'b0, 5'd0, 1'b0, 5'd0);
            settle();
        end
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b0, 5'd0);
            exp_a.push_back(32'(2 * i));
            settle();
            e = exp_a.pop_front(); vectors++;
            if (OutA !== e) begin errors++; $display("FAIL fill_read_a addr=%0d got=%h exp=%h", i, OutA, e); end
        end
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'(i));
            exp_b.push_back(32'(2 * i));
            settle();
            e = exp_b.pop_front(); vectors++;
            if (OutB !== e) begin errors++; $display("FAIL fill_read_b addr=%0d got=%h exp=%h", i, OutB, e); end
        end
    endtask

    task automatic test_dual_random();
        logic [31:0] e;
        logic [4:0]  aa, ab;
        for (int c = 0; c < 31; c++) begin
            aa = 5'($urandom_range(15, 0));
            ab = 5'($urandom_range(31, 16));
            drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, aa, 1'b1, ab);
            exp_a.push_back({26'd0, aa, 1'b0});
            exp_b.push_back({26'd0, ab, 1'b0});
            settle();
            e = exp_a.pop_front(); vectors++;
            if (OutA !== e) begin errors++; $display("FAIL dual_a addr=%0d got=%h exp=%h", aa, OutA, e); end
            e = exp_b.pop_front(); vectors++;
            if (OutB !== e) begin errors++; $display("FAIL dual_b addr=%0d got=%h exp=%h", ab, OutB, e); end
        end
    endtask

    task automatic test_enable_hold();
        logic [31:0] e;
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
        exp_a.push_back(32'd10);
        settle();
        e = exp_a.pop_front(); vectors++;
        if (OutA !== e) begin errors++; $display("FAIL hold_initial got=%h exp=%h", OutA, e); end
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd9, 1'b0, 5'd0);
            exp_a.push_back(32'd10);
            settle();
            e = exp_a.pop_front(); vectors++;
            if (OutA !== e) begin errors++; $display("FAIL hold_disabled cyc=%0d got=%h exp=%h", c, OutA, e); end
        end
        drive(1'b0, 1'b0, 5'd5, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0);
        exp_a.push_back(32'd18);
        settle();
        e = exp_a.pop_front(); vectors++;
        if (OutA !== e) begin errors++; $display("FAIL hold_reenable got=%h exp=%h", OutA, e); end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd5);
        exp_b.push_back(32'hDEADBEEF);
        settle();
        e = exp_b.pop_front(); vectors++;
        if (OutB !== e) begin errors++; $display("FAIL hold_write_landed got=%h exp=%h", OutB, e); end
    endtask

    task automatic test_bypass();
        logic [31:0] e;
        drive(1'b0, 1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7, 1'b1, 5'd7);
        exp_a.push_back(32'h12345678); exp_b.push_back(32'h12345678);
        settle();
        e = exp_a.pop_front(); vectors++;
        if (OutA !== e) begin errors++; $display("FAIL bypass_a got=%h exp=%h", OutA, e); end
        e = exp_b.pop_front(); vectors++;
        if (OutB !== e) begin errors++; $display("FAIL bypass_b got=%h exp=%h", OutB, e); end
        // Write disabled with a matching address: stored value, not In, must come back.
        drive(1'b0, 1'b0, 5'd7, 32'hA5A5A5A5, 1'b1, 5'd7, 1'b1, 5'd7);
        exp_a.push_back(32'h12345678); exp_b.push_back(32'h12345678);
        settle();
        e = exp_a.pop_front(); vectors++;
        if (OutA !== e) begin errors++; $display("FAIL bypass_stored_a got=%h exp=%h", OutA, e); end
        e = exp_b.pop_front(); vectors++;
        if (OutB !== e) begin errors++; $display("FAIL bypass_stored_b got=%h exp=%h", OutB, e); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] e;
        drive(1'b1, 1'b1, 5'd3, 32'hFFFFFFFF, 1'b1, 5'd3, 1'b1, 5'd3);
        exp_a.push_back(32'h0); exp_b.push_back(32'h0);
        settle();
        e = exp_a.pop_front(); vectors++;
        if (OutA !== e) begin errors++; $display("FAIL midrst_outa got=%h exp=%h", OutA, e); end
        e = exp_b.pop_front(); vectors++;
        if (OutB !== e) begin errors++; $display("FAIL midrst_outb got=%h exp=%h", OutB, e); end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd7);
        exp_a.push_back(32'h0); exp_b.push_back(32'h0);
        settle();
        e = exp_a.pop_front(); vectors++;
        if (OutA !== e) begin errors++; $display("FAIL midrst_addr3 got=%h exp=%h", OutA, e); end
        e = exp_b.pop_front(); vectors++;
        if (OutB !== e) begin errors++; $display("FAIL midrst_addr7 got=%h exp=%h", OutB, e); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 1'b1, 5'(i), 32'(i) * 32'h01010101, 1'b1, 5'(i - 1), 1'b1, 5'(i));
            exp_a.push_back(32'(i - 1) * 32'h01010101);
            exp_b.push_back(32'(i) * 32'h01010101);
            settle();
            e = exp_a.pop_front(); vectors++;
            if (OutA !== e) begin errors++; $display("FAIL b2b_prev_a i=%0d got=%h exp=%h", i, OutA, e); end
            e = exp_b.pop_front(); vectors++;
            if (OutB !== e) begin errors++; $display("FAIL b2b_bypass_b i=%0d got=%h exp=%h", i, OutB, e); end
        end
    endtask

    initial begin
        rst = 1'b1; In = '0; address_w = '0; enable_w = 1'b0;
        address_a = '0; enable_a = 1'b0; address_b = '0; enable_b = 1'b0;
        test_reset();
        test_fill_readback();
        test_dual_random();
        test_enable_hold();
        test_bypass();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
